// File: rtl/pbvi_pkg.sv
// pbvi_pkg: shared constants, types, FSM state and saturation helper for the
// PBVI backup datapath (step2 gamma build).
package pbvi_pkg;

  localparam int unsigned N_POINT  = 16;
  localparam int unsigned N_ACTION = 3;
  localparam int unsigned N_OBS    = 2;
  localparam int unsigned N_STATE  = 2;
  localparam int unsigned N_ALPHA  = 16;

  typedef logic [15:0] value_t;
  typedef logic [32:0] dot_t;
  typedef logic [16:0] acc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ACC,
    S_FIN,
    S_DONE
  } state_t;

  // Clamp an 18-bit unsigned sum into the 16-bit value range.
  function automatic value_t sat16(input logic [17:0] x);
    return (x > 18'h0FFFF) ? 16'hFFFF : x[15:0];
  endfunction

endpackage

// File: rtl/gamma_lane_argmax.sv
// gamma_lane_argmax: one belief-point lane. Each scan cycle it forms the
// belief . candidate dot product and keeps the candidate with the largest
// dot seen so far.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_scan      : a candidate is presented this cycle
//   i_first     : candidate index 0 (load unconditionally)
//   i_belief    : belief of this point, per state
//   i_cand      : candidate projected alpha vector, per state
//   o_best_vec  : currently selected vector, per state
module gamma_lane_argmax
  import pbvi_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_scan,
  input  logic                         i_first,
  input  logic [0:N_STATE-1][15:0]     i_belief,
  input  logic [0:N_STATE-1][15:0]     i_cand,
  output logic [0:N_STATE-1][15:0]     o_best_vec
);

  dot_t                     w_dot;
  dot_t                     r_best_dot;
  logic [0:N_STATE-1][15:0] r_best_vec;

  assign w_dot = dot_t'(i_belief[0]) * dot_t'(i_cand[0])
               + dot_t'(i_belief[1]) * dot_t'(i_cand[1]);

  // Strict greater-than: on equal dots the earliest candidate is retained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_best_dot <= '0;
      r_best_vec <= '0;
    end else if (i_scan && (i_first || (w_dot > r_best_dot))) begin
      r_best_dot <= w_dot;
      r_best_vec <= i_cand;
    end
  end

  assign o_best_vec = r_best_vec;

endmodule

// File: rtl/step2_gamma_build.sv
// step2_gamma_build: for every action and belief point, picks the best
// projected alpha vector per observation, sums over observations, discounts
// and adds the action reward. Results feed step3 action selection.
//   clk, rst_n           : clock, synchronous active-low reset
//   en                   : start pulse, restarts the block when busy
//   gamma_action_obs     : projected vectors [action][obs][alpha][state]
//   reward               : immediate reward [action][state]
//   point_belief         : belief [point][state]
//   gamma_action_belief  : registered result [action][point][state]
//   busy                 : high while a run is in progress
//   done                 : one-cycle pulse, all results valid
module step2_gamma_build #(
  parameter int unsigned N_POINT  = pbvi_pkg::N_POINT,
  parameter int unsigned N_ALPHA  = pbvi_pkg::N_ALPHA,
  parameter logic [15:0] DISCOUNT = 16'h8000
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   en,
  input  logic [0:2][0:1][0:N_ALPHA-1][0:1][15:0]                gamma_action_obs,
  input  logic [0:2][0:1][15:0]                                  reward,
  input  logic [0:N_POINT-1][0:1][15:0]                          point_belief,
  output logic [0:2][0:N_POINT-1][0:1][15:0]                     gamma_action_belief,
  output logic                                                   busy,
  output logic                                                   done
);

  import pbvi_pkg::*;

  localparam int unsigned KW = $clog2(N_ALPHA);

  state_t                              r_state;
  logic [1:0]                          r_a;
  logic                                r_o;
  logic [KW-1:0]                       r_k;
  acc_t                                r_acc [N_POINT][N_STATE];
  logic [0:2][0:N_POINT-1][0:1][15:0]  r_gab;
  logic                                r_busy;
  logic                                r_done;

  logic                                w_scan;
  logic                                w_first;
  logic [0:1][15:0]                    w_cand;
  logic [0:1][15:0]                    w_best [N_POINT];
  value_t                              w_fin  [N_POINT][N_STATE];

  assign w_scan  = (r_state == S_SCAN);
  assign w_first = (r_k == '0);
  assign w_cand  = gamma_action_obs[r_a][r_o][r_k];

  for (genvar gi = 0; gi < N_POINT; gi++) begin : g_lane
    gamma_lane_argmax u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_scan     (w_scan),
      .i_first    (w_first),
      .i_belief   (point_belief[gi]),
      .i_cand     (w_cand),
      .o_best_vec (w_best[gi])
    );
  end

  // Discounted accumulator (floor of Q0.16 multiply) plus reward, saturated.
  always_comb begin
    for (int unsigned i = 0; i < N_POINT; i++) begin
      for (int unsigned s = 0; s < N_STATE; s++) begin
        w_fin[i][s] = sat16(18'(reward[r_a][s])
                    + 18'(acc_t'((dot_t'(r_acc[i][s]) * dot_t'(DISCOUNT)) >> 16)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_o     <= 1'b0;
      r_k     <= '0;
      r_gab   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int unsigned i = 0; i < N_POINT; i++)
        for (int unsigned s = 0; s < N_STATE; s++)
          r_acc[i][s] <= '0;
    end else begin
      r_done <= 1'b0;
      if (en) begin
        // Start and restart share one path; an abandoned run never pulses done.
        r_state <= S_SCAN;
        r_a     <= '0;
        r_o     <= 1'b0;
        r_k     <= '0;
        r_busy  <= 1'b1;
        for (int unsigned i = 0; i < N_POINT; i++)
          for (int unsigned s = 0; s < N_STATE; s++)
            r_acc[i][s] <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_busy <= 1'b0;
          S_SCAN: begin
            r_k <= r_k + 1'b1;
            if (r_k == KW'(N_ALPHA - 1)) r_state <= S_ACC;
          end
          S_ACC: begin
            for (int unsigned i = 0; i < N_POINT; i++)
              for (int unsigned s = 0; s < N_STATE; s++)
                r_acc[i][s] <= r_acc[i][s] + acc_t'(w_best[i][s]);
            if (!r_o) begin
              r_o     <= 1'b1;
              r_k     <= '0;
              r_state <= S_SCAN;
            end else begin
              r_state <= S_FIN;
            end
          end
          S_FIN: begin
            for (int unsigned i = 0; i < N_POINT; i++)
              for (int unsigned s = 0; s < N_STATE; s++) begin
                r_gab[r_a][i][s] <= w_fin[i][s];
                r_acc[i][s]      <= '0;
              end
            if (r_a < 2'd2) begin
              r_a     <= r_a + 1'b1;
              r_o     <= 1'b0;
              r_k     <= '0;
              r_state <= S_SCAN;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign gamma_action_belief = r_gab;
  assign busy                = r_busy;
  assign done                = r_done;

endmodule

// File: tb/tb_step2_gamma_build.sv
module tb_step2_gamma_build;

  localparam int NP = 16;
  localparam int NK = 16;
  localparam longint DISC = 32768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [0:2][0:1][0:NK-1][0:1][15:0] g;
  logic [0:2][0:1][15:0]              rw;
  logic [0:NP-1][0:1][15:0]           bel;
  logic [0:2][0:NP-1][0:1][15:0]      gab;
  logic busy, done;

  int n_checks = 0;
  int n_errors = 0;
  longint exp_v [3][NP][2];

  always #5 clk = ~clk;

  step2_gamma_build #(.N_POINT(NP), .N_ALPHA(NK), .DISCOUNT(16'h8000)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en                  (en),
    .gamma_action_obs    (g),
    .reward              (rw),
    .point_belief        (bel),
    .gamma_action_belief (gab),
    .busy                (busy),
    .done                (done)
  );

  task automatic check(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: arg-max (first maximum) per observation, sum, discount, add reward.
  task automatic compute_model();
    for (int a = 0; a < 3; a++)
      for (int i = 0; i < NP; i++) begin
        longint acc [2];
        acc[0] = 0; acc[1] = 0;
        for (int o = 0; o < 2; o++) begin
          longint best;
          int bk;
          best = -1; bk = 0;
          for (int k = 0; k < NK; k++) begin
            longint d;
            d = longint'(bel[i][0]) * longint'(g[a][o][k][0])
              + longint'(bel[i][1]) * longint'(g[a][o][k][1]);
            if (d > best) begin best = d; bk = k; end
          end
          acc[0] += longint'(g[a][o][bk][0]);
          acc[1] += longint'(g[a][o][bk][1]);
        end
        for (int s = 0; s < 2; s++) begin
          longint v;
          v = longint'(rw[a][s]) + ((acc[s] * DISC) / 65536);
          exp_v[a][i][s] = (v > 65535) ? 65535 : v;
        end
      end
  endtask

  task automatic pulse_en();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  // Called right after pulse_en (negedge of cycle 1); returns at the done cycle.
  task automatic measure(input string tag);
    int c, done_cyc, busy_cnt, busy_at_done;
    c = 1; done_cyc = 0; busy_cnt = 0; busy_at_done = 1;
    while (c <= 300 && done_cyc == 0) begin
      if (done) begin
        done_cyc = c; busy_at_done = int'(busy);
      end else begin
        busy_cnt += int'(busy);
        @(negedge clk); c++;
      end
    end
    check({tag, "_done_cycle"}, done_cyc, 106);
    check({tag, "_busy_cycles"}, busy_cnt, 105);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic check_results(input string tag);
    for (int a = 0; a < 3; a++)
      for (int i = 0; i < NP; i++)
        for (int s = 0; s < 2; s++)
          check($sformatf("%s_gab[%0d][%0d][%0d]", tag, a, i, s), gab[a][i][s], exp_v[a][i][s]);
  endtask

  task automatic run_scenario(input string tag);
    compute_model();
    pulse_en();
    measure(tag);
    check_results(tag);
  endtask

  task automatic fill_random(input int mode);
    for (int i = 0; i < NP; i++)
      for (int s = 0; s < 2; s++)
        bel[i][s] = (mode == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
    for (int a = 0; a < 3; a++) begin
      for (int s = 0; s < 2; s++)
        rw[a][s] = (mode == 2) ? 16'($urandom_range(16'hC000, 16'hFFFF)) : 16'($urandom);
      for (int o = 0; o < 2; o++)
        for (int k = 0; k < NK; k++)
          for (int s = 0; s < 2; s++)
            case (mode)
              1:       g[a][o][k][s] = 16'($urandom_range(0, 3));
              2:       g[a][o][k][s] = 16'($urandom_range(16'hE000, 16'hFFFF));
              default: g[a][o][k][s] = 16'($urandom);
            endcase
    end
  endtask

  initial begin
    int dn;
    g = '0; rw = '0; bel = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gab_zero", (gab == '0) ? 1 : 0, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Reward passthrough
    g = '0;
    for (int a = 0; a < 3; a++) begin
      rw[a][0] = 16'(16'h0100 * (a + 1));
      rw[a][1] = 16'(16'h0200 * (a + 1));
    end
    for (int i = 0; i < NP; i++) begin
      bel[i][0] = 16'($urandom); bel[i][1] = 16'($urandom);
    end
    run_scenario("pass");
    check("pass_direct_a2", gab[2][5][1], 64'h0600);

    // Argmax
    rw = '0;
    for (int i = 0; i < NP; i++) begin bel[i][0] = 16'hFFFF; bel[i][1] = 16'h0; end
    for (int a = 0; a < 3; a++)
      for (int o = 0; o < 2; o++)
        for (int k = 0; k < NK; k++) begin
          g[a][o][k][0] = 16'(k * 16'h10);
          g[a][o][k][1] = 16'(16'hF000 - k);
        end
    run_scenario("argmax");
    check("argmax_direct0", gab[1][3][0], 64'h00F0);
    check("argmax_direct1", gab[1][3][1], 64'hEFF1);

    // Held after done
    repeat (5) @(negedge clk);
    check("hold_after_done", gab[2][15][1], 64'hEFF1);

    // Tie-break
    for (int i = 0; i < NP; i++) begin bel[i][0] = 16'h8000; bel[i][1] = 16'h8000; end
    for (int a = 0; a < 3; a++)
      for (int o = 0; o < 2; o++)
        for (int k = 0; k < NK; k++) begin
          g[a][o][k][0] = 16'(k);
          g[a][o][k][1] = 16'(16'h100 - k);
        end
    run_scenario("tie");
    check("tie_direct0", gab[0][0][0], 64'h0000);
    check("tie_direct1", gab[0][0][1], 64'h0100);

    // Saturation
    g = '1; rw = '1;
    for (int i = 0; i < NP; i++) begin bel[i][0] = 16'($urandom); bel[i][1] = 16'($urandom); end
    run_scenario("sat");
    check("sat_direct", gab[2][7][0], 64'hFFFF);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      fill_random(r % 3);
      run_scenario($sformatf("rand%0d", r));
    end

    // Restart: new stimulus presented with the second en at cycle 50
    fill_random(0);
    pulse_en();
    repeat (48) @(negedge clk);
    fill_random(1);
    compute_model();
    pulse_en();
    measure("restart");
    check_results("restart");

    // Reset mid-run
    pulse_en();
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_gab_zero", (gab == '0) ? 1 : 0, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst_n = 1'b1;
    dn = 0;
    repeat (150) begin @(negedge clk); dn += int'(done); end
    check("midrst_no_done", dn, 0);

    // en together with reset: reset wins
    rst_n = 1'b0; en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(negedge clk);
    check("en_in_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
